// File: rtl/data_mem_responder.sv
// MEM-stage data port responder: zero-wait local word RAM for low addresses,
// req/ack IO bus bridge with timeout and a sticky error flag for high addresses.
module data_mem_responder #(
  parameter int          ADDR_WIDTH = 10,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t                state, state_next;
  logic [31:0]           ram [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] idx;
  logic                  is_io;
  logic                  io_access;
  logic                  timeout_hit;
  logic [31:0]           resp;
  logic [CW-1:0]         cnt;

  assign idx         = mem_addr[ADDR_WIDTH+1:2];
  assign is_io       = mem_addr[31];
  assign io_access   = (mem_ren | mem_wen) & is_io;
  assign timeout_hit = (cnt == CNT_LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (io_access) state_next = REQ;
      REQ:     if (bus_ack || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus fields are latched once at detect so they stay stable through REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bus_we    <= 1'b0;
      bus_addr  <= 32'h0;
      bus_wdata <= 32'h0;
      resp      <= 32'h0;
      cnt       <= '0;
      bus_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && io_access) begin
        bus_addr  <= mem_addr;
        bus_wdata <= mem_dout;
        bus_we    <= mem_wen;
        cnt       <= '0;
      end
      if (state == REQ) begin
        cnt <= cnt + CW'(1);
        if (bus_ack) begin
          resp <= bus_we ? 32'h0 : bus_rdata;
        end else if (timeout_hit) begin
          resp    <= ERR_DATA;
          bus_err <= 1'b1;
        end
      end
    end
  end

  // RAM contents are deliberately not reset; writes only land while idle.
  always_ff @(posedge clk) begin
    if (rst_n && state == IDLE && mem_wen && !is_io)
      ram[idx] <= mem_dout;
  end

  assign bus_req = (state == REQ);

  always_comb begin
    mem_stall = 1'b0;
    mem_din   = 32'h0;
    if (rst_n) begin
      mem_stall = (state == REQ) || (state == IDLE && io_access);
      if (state == DONE)
        mem_din = resp;
      else if (mem_ren && !is_io)
        mem_din = ram[idx];
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a per-transaction
// cycle model (RAM array plus arithmetic on ack delay / timeout).
module tb_data_mem_responder;

  localparam int          TO   = 4;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        mem_ren = 1'b0;
  logic        mem_wen = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_dout = 32'h0;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;
  logic        bus_err;

  data_mem_responder #(.ADDR_WIDTH(10), .TIMEOUT(TO), .ERR_DATA(ERRV)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .mem_din(mem_din), .mem_stall(mem_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_ram [0:1023];
  logic        err_sticky = 1'b0;
  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_err, exp_we;
  logic [31:0] exp_din, exp_baddr, exp_bwdata;
  int          stall_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] seen;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Single compare process: every cycle the model expectations are live.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("mem_stall", {31'b0, mem_stall}, {31'b0, exp_stall});
      checkOutput("bus_req", {31'b0, bus_req}, {31'b0, exp_req});
      checkOutput("mem_din", mem_din, exp_din);
      checkOutput("bus_err", {31'b0, bus_err}, {31'b0, exp_err});
      if (exp_req) begin
        checkOutput("bus_addr", bus_addr, exp_baddr);
        checkOutput("bus_we", {31'b0, bus_we}, {31'b0, exp_we});
        checkOutput("bus_wdata", bus_wdata, exp_bwdata);
      end
      if (mem_stall === 1'b1) stall_cnt++;
      if (bus_req === 1'b1) req_cnt++;
    end
  end

  function automatic int ram_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'd1024);
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] dout, input logic ack, input logic [31:0] rdata);
    mem_ren   = ren;
    mem_wen   = wen;
    mem_addr  = addr;
    mem_dout  = dout;
    bus_ack   = ack;
    bus_rdata = rdata;
  endtask

  task automatic idle_cycle;
    next_cycle;
    applyStimulus(1'b0, 1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom);
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_din   = 32'h0;
    exp_err   = err_sticky;
    chk_en    = 1'b1;
  endtask

  task automatic local_access(input logic ren, input logic wen, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] got);
    logic [31:0] a;
    a = {1'b0, addr[30:0]};
    next_cycle;
    applyStimulus(ren, wen, a, wdata, 1'($urandom_range(0, 1)), $urandom);
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_din   = ren ? model_ram[ram_idx(a)] : 32'h0;
    exp_err   = err_sticky;
    chk_en    = 1'b1;
    #2;
    got = mem_din;
    if (wen) model_ram[ram_idx(a)] = wdata;
  endtask

  // delay = REQ cycles before the ack cycle; negative or >= TO means no ack.
  task automatic io_access(input logic ren, input logic wen, input logic [31:0] addr,
                           input logic [31:0] wdata, input int delay,
                           input logic [31:0] rdata, output logic [31:0] got);
    logic        timed_out;
    int          n_req;
    logic [31:0] a;
    logic [31:0] result;
    logic        ack;
    logic [31:0] rd;
    timed_out = (delay < 0) || (delay >= TO);
    n_req     = timed_out ? TO : delay + 1;
    a         = {1'b1, addr[30:0]};
    result    = timed_out ? ERRV : (wen ? 32'h0 : rdata);
    got       = 32'h0;
    for (int c = 0; c <= n_req + 1; c++) begin
      next_cycle;
      if (c >= 1 && c <= n_req) begin
        ack = !timed_out && (c == delay + 1);
        rd  = ack ? rdata : $urandom;
      end else begin
        ack = 1'($urandom_range(0, 1));
        rd  = $urandom;
      end
      applyStimulus(ren, wen, a, wdata, ack, rd);
      exp_stall  = (c <= n_req);
      exp_req    = (c >= 1 && c <= n_req);
      exp_din    = (c == n_req + 1) ? result : 32'h0;
      exp_err    = err_sticky | (timed_out && c == n_req + 1);
      exp_baddr  = a;
      exp_we     = wen;
      exp_bwdata = wdata;
      chk_en     = 1'b1;
      if (c == n_req + 1) begin
        #2;
        got = mem_din;
      end
    end
    if (timed_out) err_sticky = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #11;
    checkOutput("rst_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("rst_req", {31'b0, bus_req}, 32'h0);
    checkOutput("rst_err", {31'b0, bus_err}, 32'h0);
    checkOutput("rst_we", {31'b0, bus_we}, 32'h0);
    checkOutput("rst_addr", bus_addr, 32'h0);
    checkOutput("rst_wdata", bus_wdata, 32'h0);
    checkOutput("rst_din", mem_din, 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 1024; i++)
      local_access(1'b0, 1'b1, 32'(i * 4), $urandom, seen);

    stall_cnt = 0;
    local_access(1'b0, 1'b1, 32'h10, 32'h1234_5678, seen);
    local_access(1'b1, 1'b0, 32'h10, 32'h0, seen);
    checkOutput("lit_local_read", seen, 32'h1234_5678);
    local_access(1'b1, 1'b0, 32'h1010, 32'h0, seen);
    checkOutput("lit_local_alias", seen, 32'h1234_5678);
    local_access(1'b1, 1'b1, 32'h10, 32'h0BAD_F00D, seen);
    checkOutput("lit_local_rw_old", seen, 32'h1234_5678);
    local_access(1'b1, 1'b0, 32'h10, 32'h0, seen);
    checkOutput("lit_local_rw_new", seen, 32'h0BAD_F00D);
    checkOutput("lit_local_nostall", 32'(stall_cnt), 32'd0);

    stall_cnt = 0; req_cnt = 0;
    io_access(1'b1, 1'b0, 32'h8000_0040, 32'h0, 3, 32'hCAFE_0001, seen);
    checkOutput("lit_io_rd_data", seen, 32'hCAFE_0001);
    checkOutput("lit_io_rd_stall", 32'(stall_cnt), 32'd5);
    checkOutput("lit_io_rd_req", 32'(req_cnt), 32'd4);
    checkOutput("lit_io_rd_addr", bus_addr, 32'h8000_0040);
    checkOutput("lit_io_rd_we", {31'b0, bus_we}, 32'h0);

    idle_cycle;
    stall_cnt = 0; req_cnt = 0;
    io_access(1'b0, 1'b1, 32'h8000_0000, 32'hA5A5, 0, 32'h7777_7777, seen);
    checkOutput("lit_io_wr_data", seen, 32'h0);
    checkOutput("lit_io_wr_stall", 32'(stall_cnt), 32'd2);
    checkOutput("lit_io_wr_req", 32'(req_cnt), 32'd1);
    checkOutput("lit_io_wr_we", {31'b0, bus_we}, 32'h1);
    checkOutput("lit_io_wr_wdata", bus_wdata, 32'hA5A5);

    stall_cnt = 0; req_cnt = 0;
    io_access(1'b1, 1'b0, 32'h8000_0ABC, 32'h0, -1, 32'h0, seen);
    checkOutput("lit_to_data", seen, 32'hDEAD_BEEF);
    checkOutput("lit_to_req", 32'(req_cnt), 32'd4);
    checkOutput("lit_to_stall", 32'(stall_cnt), 32'd5);
    checkOutput("lit_to_err", {31'b0, bus_err}, 32'h1);
    io_access(1'b1, 1'b0, 32'h8000_0044, 32'h0, 2, 32'h1111_2222, seen);
    checkOutput("lit_after_to_data", seen, 32'h1111_2222);
    checkOutput("lit_after_to_err", {31'b0, bus_err}, 32'h1);

    io_access(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1, 32'hB2B2_0001, seen);
    checkOutput("lit_b2b_first", seen, 32'hB2B2_0001);
    io_access(1'b1, 1'b0, 32'h8000_0104, 32'h0, 2, 32'hB2B2_0002, seen);
    checkOutput("lit_b2b_second", seen, 32'hB2B2_0002);

    for (int n = 0; n < 400; n++) begin
      int          r;
      logic [1:0]  rw;
      r  = int'($urandom_range(0, 9));
      rw = 2'($urandom_range(1, 3));
      if (r < 4)
        local_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom, seen);
      else if (r < 8)
        io_access(rw[0], rw[1], $urandom, $urandom, int'($urandom_range(0, TO + 1)), $urandom, seen);
      else
        idle_cycle;
    end
    idle_cycle;

    next_cycle;
    chk_en = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h8000_0100, 32'h0, 1'b0, 32'h0);
    next_cycle;
    next_cycle;
    #2;
    checkOutput("rst_mid_req_before", {31'b0, bus_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_req", {31'b0, bus_req}, 32'h0);
    checkOutput("rst_mid_stall", {31'b0, mem_stall}, 32'h0);
    checkOutput("rst_mid_err", {31'b0, bus_err}, 32'h0);
    checkOutput("rst_mid_din", mem_din, 32'h0);
    checkOutput("rst_mid_addr", bus_addr, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    next_cycle;
    rst_n = 1'b1;
    err_sticky = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h5555_5555);
    #2;
    checkOutput("late_ack_req", {31'b0, bus_req}, 32'h0);
    checkOutput("late_ack_stall", {31'b0, mem_stall}, 32'h0);
    next_cycle;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #2;
    checkOutput("late_ack_idle_req", {31'b0, bus_req}, 32'h0);
    checkOutput("late_ack_idle_din", mem_din, 32'h0);
    checkOutput("late_ack_idle_err", {31'b0, bus_err}, 32'h0);

    io_access(1'b1, 1'b0, 32'h8000_0200, 32'h0, 1, 32'h600D_0001, seen);
    checkOutput("lit_post_rst_io", seen, 32'h600D_0001);
    local_access(1'b1, 1'b0, 32'h10, 32'h0, seen);
    idle_cycle;
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the CPU's MEM-stage data port. The pipeline drives `mem_ren`/`mem_wen`/`mem_addr`/`mem_dout` and expects `mem_din` in the same cycle; this block answers those requests. Low addresses are served zero-wait from a local word RAM. High addresses are forwarded to an external IO bus through a req/ack state machine, and `mem_stall` freezes the pipeline until the bus answers or a timeout fires.

## Interface
- `ADDR_WIDTH`, default 10: local RAM word-index width (2^ADDR_WIDTH words).
- `TIMEOUT`, default 255: REQ-state cycles allowed without `bus_ack`; must be ≥1.
- `ERR_DATA`, default 32'hDEAD_BEEF: read data returned on timeout.

Ports:
- `clk`  in  1: the single clock; all logic is on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `mem_ren`  in  1: read request from the MEM stage.
- `mem_wen`  in  1: write request from the MEM stage.
- `mem_addr`  in  32: byte address; `[1:0]` ignored.
- `mem_dout`  in  32: write data from the CPU.
- `mem_din`  out  32: read data to the CPU, valid in the cycle the access completes.
- `mem_stall`  out  1: pipeline must hold the MEM stage and everything upstream.
- `bus_req`  out  1: IO request, held until ack or timeout.
- `bus_we`  out  1: IO request is a write.
- `bus_addr`  out  32: latched IO address.
- `bus_wdata`  out  32: latched IO write data.
- `bus_rdata`  in  32: IO read data, sampled when `bus_ack`=1.
- `bus_ack`  in  1: IO completion, one cycle per request.
- `bus_err`  out  1: sticky flag, set on timeout.

## Operation
- Decode: `mem_addr[31]`=0 selects local RAM; 1 selects IO.
- An access is present when `mem_ren|mem_wen` is 1.
- **Local RAM**
  - Index is `mem_addr[ADDR_WIDTH+1:2]`; upper bits alias.
  - Read is combinational: `mem_din = ram[idx]` while `mem_ren`=1 and addr[31]=0.
  - Write commits on the clock edge when `mem_wen`=1 and state is IDLE.
  - `mem_ren` and `mem_wen` together: read returns the old word and the write commits.
  - Local accesses never stall. RAM contents are not reset.
- **IO FSM (states IDLE, REQ, DONE)**
  - IDLE: an IO access drives `mem_stall`=1 combinationally in the same cycle. The edge latches `bus_addr`, `bus_wdata`, and `bus_we`=`mem_wen`, and moves to REQ.
  - REQ: `bus_req`=1 and `mem_stall`=1; the timeout counter increments.
    - `bus_ack`=1: capture `bus_rdata` (read) or 0 (write) into the response register; go to DONE.
    - Counter reaches TIMEOUT with no ack: capture ERR_DATA, set `bus_err`, go to DONE.
  - DONE: `mem_stall`=0 and `mem_din` = response register, so the pipeline advances. Always returns to IDLE; the still-present request is not re-issued.
  - The next IO access (back-to-back) is detected in the following IDLE cycle.
- IO access with both `mem_ren` and `mem_wen`: treated as a write; `mem_din` returns 0.
- `bus_ack` in IDLE or DONE is ignored.
- `mem_din` is 0 when there is no access.
- **Reset (any time, including mid-REQ):** state IDLE; `bus_req`, `bus_we`, `mem_stall`, and `bus_err` are 0; `bus_addr`, `bus_wdata`, the response register and the counter are 0; `mem_din` is 0. An in-flight bus transaction is abandoned.

## Timing
- Local read: 0-cycle latency. Local write: visible to a read in the cycle after the edge.
- IO access with ack N cycles after `bus_req` rises (N≥0, same-cycle ack is N=0):
  - `mem_stall` is high for N+2 cycles (IDLE detect, then REQ cycles).
  - `mem_din` is valid in the DONE cycle that follows.
- `bus_req` is high from the cycle after detect through the ack cycle inclusive.
- `bus_addr`, `bus_wdata` and `bus_we` are stable for the whole REQ interval.
- Timeout: `bus_req` is held for exactly TIMEOUT cycles. `bus_err` rises at the edge leaving REQ and stays high until reset.
- Minimum IO throughput: one access per 3 cycles.

## Test plan
- **Local RAM:** write 32'h1234_5678 to addr 0x10, then read 0x10 next cycle → `mem_din`=32'h1234_5678, `mem_stall` never 1. Read 0x1010 with ADDR_WIDTH=10 → same word (alias).
- **IO read, ack after 3 cycles:** read 0x8000_0040, `bus_ack` with `bus_rdata`=32'hCAFE_0001 → stall 5 cycles, `bus_req` 4 cycles, `bus_addr`=0x8000_0040, `bus_we`=0, then `mem_din`=32'hCAFE_0001 with stall=0 for one cycle.
- **IO write, same-cycle ack:** write 32'hA5A5 to 0x8000_0000, ack in the first REQ cycle → stall 2 cycles, `bus_we`=1, `bus_wdata`=32'hA5A5. Held request is not re-issued in DONE.
- **Timeout:** TIMEOUT=4, no ack → `bus_req` high 4 cycles, then `mem_din`=32'hDEAD_BEEF, `bus_err`=1 sticky. A later acked access still completes and `bus_err` stays 1.
- **Reset mid-REQ:** pull `rst_n` low during REQ → `bus_req` and `mem_stall` drop immediately, `bus_err`=0. A late `bus_ack` after release is ignored, FSM stays IDLE.
- **Back-to-back IO accesses:** two consecutive IO reads → second detected the cycle after DONE, each gets its own `bus_req` pulse and correct data.
